// File: rtl/uart_csr_pkg.sv
// rtl/uart_csr_pkg.sv - register map, reset values and field layouts for the UART CSR bank
package uart_csr_pkg;

   localparam logic [2:0] OFF_BAUD    = 3'd0;
   localparam logic [2:0] OFF_CTRL    = 3'd1;
   localparam logic [2:0] OFF_STATUS  = 3'd2;
   localparam logic [2:0] OFF_IRQ_EN  = 3'd3;
   localparam logic [2:0] OFF_ERR_CNT = 3'd4;

   localparam int ST_BUSY     = 0;
   localparam int ST_PARITY   = 1;
   localparam int ST_FRAMING  = 2;
   localparam int ST_DATABITS = 3;

   localparam logic [15:0] BAUD_RST = 16'h0364;
   localparam logic [7:0]  CTRL_RST = 8'h08;

   typedef struct packed {
      logic       enable;
      logic       stop2;
      logic       parity_odd;
      logic       parity_en;
      logic [3:0] data_bits;
   } uart_ctrl_t;

   typedef struct packed {
      logic data_bits_err;
      logic framing_err;
      logic parity_err;
      logic busy;
   } uart_status_t;

   // Enables line up with STATUS[3:1]; bit 0 of the register is not stored.
   typedef struct packed {
      logic data_bits_err;
      logic framing_err;
      logic parity_err;
   } uart_irq_en_t;

   function automatic logic data_bits_illegal(input logic [3:0] n);
      return (n < 4'd5) || (n > 4'd8);
   endfunction

endpackage

// File: rtl/uart_csr_chan.sv
// rtl/uart_csr_chan.sv - one UART channel: config registers, sticky status, error counter, irq
module uart_csr_chan
   import uart_csr_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int BAUD_W      = 16,
   parameter int CNT_W       = 8,
   parameter int CLR_ON_READ = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              we_baud_i,
   input  logic              we_ctrl_i,
   input  logic              we_status_i,
   input  logic              we_irq_en_i,
   input  logic              we_cnt_i,
   input  logic              re_status_i,
   input  logic              parity_error_i,
   input  logic              framing_error_i,
   input  logic              busy_i,
   output logic [BAUD_W-1:0] baud_o,
   output uart_ctrl_t        ctrl_o,
   output uart_status_t      status_o,
   output uart_irq_en_t      irq_en_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              irq_o
);

   logic [BAUD_W-1:0] baud_q, baud_d;
   uart_ctrl_t        ctrl_q, ctrl_d;
   uart_status_t      status_q, status_d;
   uart_irq_en_t      irq_en_q, irq_en_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [2:0] err_clr, err_set, err_nxt, err_q;

   assign err_q = {status_q.data_bits_err, status_q.framing_err, status_q.parity_err};

   always_comb begin
      baud_d   = baud_q;
      ctrl_d   = ctrl_q;
      irq_en_d = irq_en_q;
      cnt_d    = cnt_q;
      err_clr  = '0;

      if (we_baud_i)   baud_d   = wdata_i[BAUD_W-1:0];
      if (we_ctrl_i)   ctrl_d   = uart_ctrl_t'(wdata_i[7:0]);
      if (we_irq_en_i) irq_en_d = uart_irq_en_t'(wdata_i[3:1]);

      if (CLR_ON_READ == 0) begin
         if (we_status_i) err_clr = wdata_i[3:1];
      end else if (re_status_i) begin
         err_clr = '1;
      end

      // Set is OR-ed after the clear so a same-cycle event always survives.
      err_set  = {data_bits_illegal(ctrl_q.data_bits), framing_error_i, parity_error_i};
      err_nxt  = (err_q & ~err_clr) | err_set;
      status_d = '{data_bits_err: err_nxt[2], framing_err: err_nxt[1],
                   parity_err: err_nxt[0], busy: busy_i};

      if (we_cnt_i)
         cnt_d = CNT_W'(parity_error_i);
      else if (parity_error_i && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         baud_q   <= BAUD_W'(BAUD_RST);
         ctrl_q   <= uart_ctrl_t'(CTRL_RST);
         status_q <= '0;
         irq_en_q <= '0;
         cnt_q    <= '0;
      end else begin
         baud_q   <= baud_d;
         ctrl_q   <= ctrl_d;
         status_q <= status_d;
         irq_en_q <= irq_en_d;
         cnt_q    <= cnt_d;
      end
   end

   assign baud_o   = baud_q;
   assign ctrl_o   = ctrl_q;
   assign status_o = status_q;
   assign irq_en_o = irq_en_q;
   assign cnt_o    = cnt_q;
   assign irq_o    = |(err_q & irq_en_q);

endmodule

// File: rtl/uart_csr_bank.sv
// rtl/uart_csr_bank.sv - multi-channel UART CSR bank: address decode, read mux, registered read port
module uart_csr_bank
   import uart_csr_pkg::*;
#(
   parameter  int N_CH        = 4,
   parameter  int DATA_W      = 32,
   parameter  int BAUD_W      = 16,
   parameter  int CNT_W       = 8,
   parameter  int CLR_ON_READ = 0,
   localparam int ADDR_W      = $clog2(N_CH) + 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   wen,
   input  logic [ADDR_W-1:0]      rd_addr,
   input  logic                   ren,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   input  logic [N_CH-1:0]        parity_error,
   input  logic [N_CH-1:0]        framing_error,
   input  logic [N_CH-1:0]        busy,
   output logic [N_CH*BAUD_W-1:0] baud_div,
   output logic [N_CH*8-1:0]      ctrl,
   output logic [N_CH-1:0]        irq,
   output logic                   irq_any
);

   logic [ADDR_W-1:0] wr_ch, rd_ch;
   logic [2:0]        wr_off, rd_off;

   assign wr_ch  = wr_addr >> 3;
   assign rd_ch  = rd_addr >> 3;
   assign wr_off = wr_addr[2:0];
   assign rd_off = rd_addr[2:0];

   logic [BAUD_W-1:0] baud_arr [N_CH];
   uart_ctrl_t        ctrl_arr [N_CH];
   uart_status_t      st_arr   [N_CH];
   uart_irq_en_t      en_arr   [N_CH];
   logic [CNT_W-1:0]  cnt_arr  [N_CH];

   // Channel indices at or above N_CH never match, so such accesses fall through.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic wsel, rsel;
      assign wsel = wen && (wr_ch == ADDR_W'(i));
      assign rsel = ren && (rd_ch == ADDR_W'(i));

      uart_csr_chan #(
         .DATA_W      (DATA_W),
         .BAUD_W      (BAUD_W),
         .CNT_W       (CNT_W),
         .CLR_ON_READ (CLR_ON_READ)
      ) u_chan (
         .clk_i           (clk),
         .rst_i           (rst),
         .wdata_i         (wr_data),
         .we_baud_i       (wsel && (wr_off == OFF_BAUD)),
         .we_ctrl_i       (wsel && (wr_off == OFF_CTRL)),
         .we_status_i     (wsel && (wr_off == OFF_STATUS)),
         .we_irq_en_i     (wsel && (wr_off == OFF_IRQ_EN)),
         .we_cnt_i        (wsel && (wr_off == OFF_ERR_CNT)),
         .re_status_i     (rsel && (rd_off == OFF_STATUS)),
         .parity_error_i  (parity_error[i]),
         .framing_error_i (framing_error[i]),
         .busy_i          (busy[i]),
         .baud_o          (baud_arr[i]),
         .ctrl_o          (ctrl_arr[i]),
         .status_o        (st_arr[i]),
         .irq_en_o        (en_arr[i]),
         .cnt_o           (cnt_arr[i]),
         .irq_o           (irq[i])
      );

      assign baud_div[i*BAUD_W +: BAUD_W] = baud_arr[i];
      assign ctrl[i*8 +: 8]               = ctrl_arr[i];
   end

   logic [DATA_W-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (rd_ch == ADDR_W'(i)) begin
            case (rd_off)
               OFF_BAUD:    rd_mux = DATA_W'(baud_arr[i]);
               OFF_CTRL:    rd_mux = DATA_W'(ctrl_arr[i]);
               OFF_STATUS:  rd_mux = DATA_W'(st_arr[i]);
               OFF_IRQ_EN:  rd_mux = DATA_W'({en_arr[i], 1'b0});
               OFF_ERR_CNT: rd_mux = DATA_W'(cnt_arr[i]);
               default:     rd_mux = '0;
            endcase
         end
      end
   end

   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q;

   assign rd_data_d = ren ? rd_mux : rd_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= ren;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq_any  = |irq;

endmodule

// File: tb/tb_uart_csr_bank.sv
// tb/tb_uart_csr_bank.sv - scoreboard bench for uart_csr_bank, W1C and clear-on-read builds side by side
module tb_uart_csr_bank;

   localparam int N  = 6;
   localparam int DW = 32;
   localparam int BW = 16;
   localparam int CW = 8;
   localparam int AW = $clog2(N) + 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, wen, ren;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic [N-1:0]  parity_error, framing_error, busy;

   logic [DW-1:0]   rd_data0, rd_data1;
   logic            rd_valid0, rd_valid1, irq_any0, irq_any1;
   logic [N*BW-1:0] baud_div0, baud_div1;
   logic [N*8-1:0]  ctrl0, ctrl1;
   logic [N-1:0]    irq0, irq1;

   uart_csr_bank #(.N_CH(N), .DATA_W(DW), .BAUD_W(BW), .CNT_W(CW), .CLR_ON_READ(0)) dut0 (
      .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen),
      .rd_addr(rd_addr), .ren(ren), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .parity_error(parity_error), .framing_error(framing_error), .busy(busy),
      .baud_div(baud_div0), .ctrl(ctrl0), .irq(irq0), .irq_any(irq_any0));

   uart_csr_bank #(.N_CH(N), .DATA_W(DW), .BAUD_W(BW), .CNT_W(CW), .CLR_ON_READ(1)) dut1 (
      .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen),
      .rd_addr(rd_addr), .ren(ren), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .parity_error(parity_error), .framing_error(framing_error), .busy(busy),
      .baud_div(baud_div1), .ctrl(ctrl1), .irq(irq1), .irq_any(irq_any1));

   // Reference state per build (index 0 = W1C, 1 = clear-on-read), one entry per channel.
   int          m_baud [2][N];
   int          m_ctrl [2][N];
   int          m_st   [2][N];
   int          m_en   [2][N];
   int          m_cnt  [2][N];
   logic [31:0] m_rd   [2];
   logic        m_rv   [2];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_read(input int d, input int a);
      int ch, off;
      ch  = a / 8;
      off = a % 8;
      if (ch >= N) return 0;
      case (off)
         0: return m_baud[d][ch];
         1: return m_ctrl[d][ch];
         2: return m_st[d][ch];
         3: return m_en[d][ch];
         4: return m_cnt[d][ch];
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      int wch, woff, rch, roff, clr, set, dbits;
      logic [31:0] rv;
      wch  = int'(wr_addr) / 8;
      woff = int'(wr_addr) % 8;
      rch  = int'(rd_addr) / 8;
      roff = int'(rd_addr) % 8;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int c = 0; c < N; c++) begin
               m_baud[d][c] = 'h364; m_ctrl[d][c] = 8; m_st[d][c] = 0;
               m_en[d][c] = 0; m_cnt[d][c] = 0;
            end
            m_rd[d] = 0;
            m_rv[d] = 0;
         end else begin
            if (ren) begin
               rv = model_read(d, int'(rd_addr));
               m_rd[d] = rv;
               if (d == 0) exp_q0.push_back(rv);
               else        exp_q1.push_back(rv);
            end
            m_rv[d] = ren;
            for (int c = 0; c < N; c++) begin
               bit wsel;
               wsel  = wen && (wch == c);
               dbits = m_ctrl[d][c] % 16;
               clr   = 0;
               if (d == 0 && wsel && woff == 2) clr = int'(wr_data) & 'hE;
               if (d == 1 && ren && rch == c && roff == 2) clr = 'hE;
               set = (parity_error[c] ? 2 : 0) | (framing_error[c] ? 4 : 0) |
                     ((dbits < 5 || dbits > 8) ? 8 : 0);
               m_st[d][c] = (((m_st[d][c] & 'hE) & ~clr) | set) | (busy[c] ? 1 : 0);
               if (wsel && woff == 4)
                  m_cnt[d][c] = parity_error[c] ? 1 : 0;
               else if (parity_error[c] && m_cnt[d][c] < 255)
                  m_cnt[d][c] = m_cnt[d][c] + 1;
               if (wsel && woff == 0) m_baud[d][c] = int'(wr_data) & 'hFFFF;
               if (wsel && woff == 1) m_ctrl[d][c] = int'(wr_data) & 'hFF;
               if (wsel && woff == 3) m_en[d][c]   = int'(wr_data) & 'hE;
            end
         end
      end
   end

   task automatic mon(input int d, input logic v, input logic [31:0] rdat, input logic [N-1:0] iq,
                      input logic ia, input logic [N*BW-1:0] bd, input logic [N*8-1:0] ct);
      logic [31:0] e;
      logic [N-1:0] eirq;
      chk($sformatf("dut%0d rd_valid", d), v, m_rv[d]);
      if (v) begin
         if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL dut%0d rd_data unexpected read actual=0x%0h required=none", d, rdat);
         end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk($sformatf("dut%0d rd_data", d), rdat, e);
         end
      end else begin
         chk($sformatf("dut%0d rd_data hold", d), rdat, m_rd[d]);
      end
      for (int c = 0; c < N; c++) begin
         eirq[c] = (m_st[d][c] & m_en[d][c] & 'hE) != 0;
         chk($sformatf("dut%0d baud_div[%0d]", d, c), 32'(bd[c*BW +: BW]), m_baud[d][c]);
         chk($sformatf("dut%0d ctrl[%0d]", d, c), 32'(ct[c*8 +: 8]), m_ctrl[d][c]);
      end
      chk($sformatf("dut%0d irq", d), 32'(iq), 32'(eirq));
      chk($sformatf("dut%0d irq_any", d), 32'(ia), 32'(|eirq));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         mon(0, rd_valid0, rd_data0, irq0, irq_any0, baud_div0, ctrl0);
         mon(1, rd_valid1, rd_data1, irq1, irq_any1, baud_div1, ctrl1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int dat);
      wen = 1; wr_addr = AW'(a); wr_data = dat;
      tick();
      wen = 0;
   endtask

   task automatic rd(input int a);
      ren = 1; rd_addr = AW'(a);
      tick();
      ren = 0;
   endtask

   initial begin
      rst = 1; wen = 0; ren = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
      parity_error = '0; framing_error = '0; busy = '0;
      tick(); tick();
      rst = 0;
      chk_en = 1;

      for (int o = 0; o < 8; o++) rd(o);

      wr(2*8+1, 'h03); tick(); rd(2*8+2);
      wr(2*8+1, 'h08); wr(2*8+2, 'h8); rd(2*8+2);

      repeat (300) begin parity_error = 6'b000010; tick(); end
      parity_error = '0;
      rd(1*8+4); wr(1*8+4, 0); rd(1*8+4);

      wr(3*8+3, 'h2);
      framing_error = 6'b001000; tick(); framing_error = '0; tick();
      chk("directed irq_any after framing", 32'(irq_any0), 0);
      parity_error = 6'b001000; tick(); parity_error = '0;
      chk("directed irq[3] after parity", 32'(irq0[3]), 1);
      wr(3*8+2, 'h2);
      chk("directed irq_any after w1c", 32'(irq_any0), 0);

      rd(2);
      parity_error = 6'b000001; ren = 1; rd_addr = AW'(2); tick();
      parity_error = '0; ren = 0;
      rd(2); rd(2);

      wr(6*8+0, 'h1234); wr(7*8+1, 'hFF); wr(7*8+4, 0);
      rd(6*8+0); rd(7*8+1); rd(0); rd(1*8+4);

      wen = 1; wr_addr = AW'(8); wr_data = 'h0ABC; ren = 1; rd_addr = AW'(8); tick();
      wen = 0; ren = 0; rd(8);

      framing_error = 6'b000010; wen = 1; wr_addr = AW'(1*8+2); wr_data = 'hF; tick();
      framing_error = '0; wen = 0; rd(1*8+2);

      parity_error = '1; framing_error = '1; busy = '1; tick();
      parity_error = '0; framing_error = '0; busy = '0; tick();
      for (int c = 0; c < N; c++) rd(c*8+2);

      wen = 1; wr_addr = AW'(0); wr_data = 'h5555; ren = 1; rd_addr = AW'(9);
      parity_error = '1; rst = 1; tick();
      rst = 0; wen = 0; ren = 0; parity_error = '0;
      rd(0); rd(4);

      for (int k = 0; k < 1500; k++) begin
         rst           = ($urandom_range(0, 199) == 0);
         wen           = $urandom_range(0, 2) == 0;
         ren           = $urandom_range(0, 1) == 0;
         wr_addr       = AW'($urandom_range(0, 63));
         rd_addr       = AW'($urandom_range(0, 63));
         wr_data       = $urandom;
         parity_error  = N'($urandom & $urandom & $urandom);
         framing_error = N'($urandom & $urandom & $urandom);
         busy          = N'($urandom);
         tick();
      end
      rst = 0; wen = 0; ren = 0; parity_error = '0; framing_error = '0; busy = '0;
      tick(); tick(); tick();

      chk("dut0 scoreboard drained", exp_q0.size(), 0);
      chk("dut1 scoreboard drained", exp_q1.size(), 0);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
